pipeline_hazard_ctrl: RTL
=========================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter: TIMEOUT, default 64, max consecutive DWAIT cycles before error.
REQ-002 Parameter: CNT_W, default 16, width of stall_cycles.
REQ-003 clk  input  1  pipeline clock, rising edge.
REQ-004 global_rst_n  input  1  asynchronous, active-low reset.
REQ-005 dmem_req  input  1  valid load/store in memory stage.
REQ-006 dmem_stall  input  1  data memory not ready this cycle.
REQ-007 dmem_done  input  1  data memory access complete this cycle.
REQ-008 imem_stall  input  1  instruction memory not ready this cycle.
REQ-009 load_use_hazard  input  1  decode needs a load result still in execute.
REQ-010 branch_flush  input  1  branch/jump resolved taken in execute.
REQ-011 halt_EM  input  1  HALT instruction in memory stage.
REQ-012 pc_freeze  output  1  hold PC.
REQ-013 freeze_FD, freeze_DE, freeze_EM, freeze_MWB  output  1 each  hold the matching pipeline register.
REQ-014 clr_FD, clr_DE, clr_EM, clr_MWB  output  1 each  local_clr to the matching pipeline register (inserts bubble).
REQ-015 halted  output  1  core halted.
REQ-016 err  output  1  sticky data-memory timeout.
REQ-017 state  output  2  current FSM state.
REQ-018 stall_cycles  output  CNT_W  count of stall cycles.

Function
REQ-019 States SHALL be RUN=2'b00, DWAIT=2'b01, HALTED=2'b10; 2'b11 unreachable, SHALL decode as HALTED.
REQ-020 All freeze/clr outputs SHALL be combinational from state and inputs; state, err, halted, stall_cycles and timeout counter SHALL be registered.
REQ-021 Outputs not asserted by a rule below SHALL be 0.
REQ-022 RUN priority, highest first: dmem stall, branch_flush, load_use_hazard, imem_stall.
REQ-023 RUN, dmem_req & dmem_stall & ~dmem_done: pc_freeze, freeze_FD, freeze_DE, freeze_EM = 1, clr_MWB = 1; next state DWAIT.
REQ-024 RUN, branch_flush (no dmem stall): clr_FD = 1, clr_DE = 1, no freezes.
REQ-025 RUN, load_use_hazard (no higher source): pc_freeze = 1, freeze_FD = 1, clr_DE = 1.
REQ-026 RUN, imem_stall (no higher source): pc_freeze = 1, clr_FD = 1.
REQ-027 DWAIT, ~dmem_done: same outputs as REQ-023; branch_flush, load_use_hazard, imem_stall ignored.
REQ-028 DWAIT, dmem_done: evaluate as RUN with dmem stall treated false; next state RUN.
REQ-029 dmem_done in RUN with dmem_stall high: done wins, no stall.
REQ-030 Timeout counter SHALL clear on DWAIT entry, increment each DWAIT cycle without dmem_done; reaching TIMEOUT SHALL set err and move to HALTED next cycle.
REQ-031 halt_EM in RUN, not stalled: next state HALTED; current-cycle outputs per REQ-022..026.
REQ-032 halt_EM in DWAIT: ignored until dmem_done cycle.
REQ-033 HALTED: pc_freeze and all four freezes = 1, all clr = 0, halted = 1; exit only by reset.
REQ-034 stall_cycles SHALL increment in any non-HALTED cycle with pc_freeze = 1, saturating at 2^CNT_W-1.
REQ-035 branch_flush ANDed with load_use_hazard: flush wins, no freeze (squashed instruction needs no stall).

Reset
REQ-036 global_rst_n low SHALL immediately force state RUN, err 0, halted 0, stall_cycles 0, timeout counter 0, independent of clk.
REQ-037 Reset asserted mid-DWAIT or in HALTED SHALL abort to RUN; first post-release edge evaluates RUN rules.

Verification
REQ-038 dmem_req&dmem_stall 3 cycles, then dmem_done -> state 01 for 3 cycles, clr_MWB=1 and freeze_EM=1 each, RUN after done, stall_cycles=3.
REQ-039 load_use_hazard 1 cycle with branch_flush=0 -> pc_freeze=1, freeze_FD=1, clr_DE=1; same with branch_flush=1 -> clr_FD=clr_DE=1, pc_freeze=0.
REQ-040 dmem_stall held with TIMEOUT=4, no done -> err=1, state=10, halted=1 after 5th edge; all freezes 1.
REQ-041 halt_EM=1 in RUN -> next cycle halted=1, state 10; stays through 10 cycles of any inputs.
REQ-042 CNT_W=2, 5 imem_stall cycles -> stall_cycles saturates at 3.
REQ-043 global_rst_n low mid-DWAIT between edges -> state 00, counters 0 before next edge.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: turns memory stalls, flushes and load-use hazards
// into per-stage freeze/clear controls, and tracks halt, timeout and stall count.
module pipeline_hazard_ctrl #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             global_rst_n,
  input  logic             dmem_req,
  input  logic             dmem_stall,
  input  logic             dmem_done,
  input  logic             imem_stall,
  input  logic             load_use_hazard,
  input  logic             branch_flush,
  input  logic             halt_EM,
  output logic             pc_freeze,
  output logic             freeze_FD,
  output logic             freeze_DE,
  output logic             freeze_EM,
  output logic             freeze_MWB,
  output logic             clr_FD,
  output logic             clr_DE,
  output logic             clr_EM,
  output logic             clr_MWB,
  output logic             halted,
  output logic             err,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_DWAIT   = 2'b01,
    ST_HALTED  = 2'b10,
    ST_ILLEGAL = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             err_q, err_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic dstall_run;
  logic in_halt;
  logic mem_hold;

  // A completing access beats a concurrent stall indication.
  assign dstall_run = dmem_req & dmem_stall & ~dmem_done;

  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      state_q  <= ST_RUN;
      tmo_q    <= '0;
      err_q    <= 1'b0;
      halted_q <= 1'b0;
      stall_q  <= '0;
    end else begin
      state_q  <= state_d;
      tmo_q    <= tmo_d;
      err_q    <= err_d;
      halted_q <= halted_d;
      stall_q  <= stall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    case (state_q)
      ST_RUN: begin
        if (dstall_run) begin
          state_d = ST_DWAIT;
          tmo_d   = '0;
        end else if (halt_EM) begin
          state_d = ST_HALTED;
        end
      end
      ST_DWAIT: begin
        if (dmem_done) begin
          state_d = halt_EM ? ST_HALTED : ST_RUN;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ST_HALTED;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: state_d = ST_HALTED;
    endcase

    halted_d = halted_q | ((state_d != ST_RUN) && (state_d != ST_DWAIT));

    stall_d = stall_q;
    if (!in_halt && pc_freeze && (stall_q != '1)) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  // A DWAIT cycle that sees dmem_done falls through to the ordinary RUN priority chain.
  always_comb begin
    in_halt    = (state_q == ST_HALTED) || (state_q == ST_ILLEGAL);
    mem_hold   = ((state_q == ST_RUN) && dstall_run) ||
                 ((state_q == ST_DWAIT) && !dmem_done);
    pc_freeze  = 1'b0;
    freeze_FD  = 1'b0;
    freeze_DE  = 1'b0;
    freeze_EM  = 1'b0;
    freeze_MWB = 1'b0;
    clr_FD     = 1'b0;
    clr_DE     = 1'b0;
    clr_EM     = 1'b0;
    clr_MWB    = 1'b0;
    if (in_halt) begin
      pc_freeze  = 1'b1;
      freeze_FD  = 1'b1;
      freeze_DE  = 1'b1;
      freeze_EM  = 1'b1;
      freeze_MWB = 1'b1;
    end else if (mem_hold) begin
      pc_freeze = 1'b1;
      freeze_FD = 1'b1;
      freeze_DE = 1'b1;
      freeze_EM = 1'b1;
      clr_MWB   = 1'b1;
    end else if (branch_flush) begin
      clr_FD = 1'b1;
      clr_DE = 1'b1;
    end else if (load_use_hazard) begin
      pc_freeze = 1'b1;
      freeze_FD = 1'b1;
      clr_DE    = 1'b1;
    end else if (imem_stall) begin
      pc_freeze = 1'b1;
      clr_FD    = 1'b1;
    end
  end

  assign state        = state_q;
  assign err          = err_q;
  assign halted       = halted_q;
  assign stall_cycles = stall_q;

endmodule
